// File: rtl/mul_seq_qfmt.sv
// rtl/mul_seq_qfmt.sv - sequential signed Q-format multiplier, RB bits per cycle with early exit
module mul_seq_qfmt #(
    parameter int DW = 16,
    parameter int FW = 13,
    parameter int RB = 5
) (
    input  logic          I_CLK,
    input  logic          I_RST_N,
    input  logic          I_VLD,
    output logic          O_READY,
    input  logic [DW-1:0] I_M1,
    input  logic [DW-1:0] I_M2,
    input  logic          I_RND,
    output logic          O_VLD,
    output logic [DW-1:0] O_PRODUCT,
    output logic          O_OVF
);

    localparam int AW = 2 * DW;
    localparam logic [DW-1:0] ONE     = {{(DW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] HALF    = ({{(AW-1){1'b0}}, 1'b1} << FW) >> 1;
    localparam logic [AW-1:0] MAX_POS = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic [AW-1:0] MIN_MAG = {{(AW-DW){1'b0}}, 1'b1, {(DW-1){1'b0}}};

    // Result formation happens on the ACC exit edge, so no separate OUT wait state exists.
    typedef enum logic {S_IDLE, S_ACC} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] acc;
    logic [AW-1:0] m1_sh;
    logic [DW-1:0] m2_rem;
    logic          sign;
    logic          rnd;

    logic [DW-1:0] m1_abs, m2_abs;
    logic [AW-1:0] partial;
    logic [AW-1:0] q;
    logic [DW-1:0] res;
    logic          res_ovf;
    logic          accept;
    logic          rem_zero;

    assign m1_abs   = I_M1[DW-1] ? (~I_M1 + ONE) : I_M1;
    assign m2_abs   = I_M2[DW-1] ? (~I_M2 + ONE) : I_M2;
    assign partial  = m1_sh * {{(AW-RB){1'b0}}, m2_rem[RB-1:0]};
    assign q        = (acc + (rnd ? HALF : '0)) >> FW;
    assign accept   = (state == S_IDLE) && I_VLD;
    assign rem_zero = (m2_rem == '0);
    assign O_READY  = (state == S_IDLE);

    always_comb begin
        res     = q[DW-1:0];
        res_ovf = 1'b0;
        if (!sign) begin
            if (q > MAX_POS) begin
                res     = MAX_POS[DW-1:0];
                res_ovf = 1'b1;
            end
        end else if (q > MIN_MAG) begin
            res     = MIN_MAG[DW-1:0];
            res_ovf = 1'b1;
        end else begin
            // Negating zero stays zero, so no negative-zero special case is needed.
            res = ~q[DW-1:0] + ONE;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (I_VLD) state_nxt = S_ACC;
            S_ACC:  if (rem_zero) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            acc       <= '0;
            m1_sh     <= '0;
            m2_rem    <= '0;
            sign      <= 1'b0;
            rnd       <= 1'b0;
            O_VLD     <= 1'b0;
            O_PRODUCT <= '0;
            O_OVF     <= 1'b0;
        end else begin
            O_VLD     <= 1'b0;
            O_PRODUCT <= '0;
            O_OVF     <= 1'b0;
            if (accept) begin
                acc    <= '0;
                m1_sh  <= {{DW{1'b0}}, m1_abs};
                m2_rem <= m2_abs;
                sign   <= I_M1[DW-1] ^ I_M2[DW-1];
                rnd    <= I_RND;
            end else if (state == S_ACC) begin
                if (!rem_zero) begin
                    acc    <= acc + partial;
                    m1_sh  <= m1_sh << RB;
                    m2_rem <= m2_rem >> RB;
                end else begin
                    O_VLD     <= 1'b1;
                    O_PRODUCT <= res;
                    O_OVF     <= res_ovf;
                end
            end
        end
    end

endmodule

// File: tb/tb_mul_seq_qfmt.sv
// tb/tb_mul_seq_qfmt.sv - scoreboard bench for mul_seq_qfmt
module tb_mul_seq_qfmt;

    localparam int DW = 16;
    localparam int FW = 13;
    localparam int RB = 5;

    logic          I_CLK = 1'b0;
    logic          I_RST_N;
    logic          I_VLD;
    logic          O_READY;
    logic [DW-1:0] I_M1;
    logic [DW-1:0] I_M2;
    logic          I_RND;
    logic          O_VLD;
    logic [DW-1:0] O_PRODUCT;
    logic          O_OVF;

    typedef struct {
        logic [DW-1:0] p;
        logic          ovf;
        int            vc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    mul_seq_qfmt #(.DW(DW), .FW(FW), .RB(RB)) dut (
        .I_CLK     (I_CLK),
        .I_RST_N   (I_RST_N),
        .I_VLD     (I_VLD),
        .O_READY   (O_READY),
        .I_M1      (I_M1),
        .I_M2      (I_M2),
        .I_RND     (I_RND),
        .O_VLD     (O_VLD),
        .O_PRODUCT (O_PRODUCT),
        .O_OVF     (O_OVF)
    );

    always #5 I_CLK = ~I_CLK;
    always @(posedge I_CLK) cyc <= cyc + 1;

    function automatic int digits(input logic [DW-1:0] b);
        logic [DW-1:0] m;
        int n;
        m = b[DW-1] ? (~b + 16'd1) : b;
        n = 0;
        while (m != 0) begin
            m = m >> RB;
            n++;
        end
        return n;
    endfunction

    function automatic void model(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic r,
                                  output logic [DW-1:0] p, output logic ovf);
        longint sa, sb2, prod, mag, q;
        bit neg;
        sa   = longint'($signed(a));
        sb2  = longint'($signed(b));
        prod = sa * sb2;
        neg  = prod < 0;
        mag  = neg ? -prod : prod;
        q    = (mag + (r ? (64'sd1 <<< (FW - 1)) : 64'sd0)) >>> FW;
        ovf  = 1'b0;
        if (!neg) begin
            if (q > 32767) begin p = 16'h7FFF; ovf = 1'b1; end
            else p = q[DW-1:0];
        end else begin
            if (q > 32768) begin p = 16'h8000; ovf = 1'b1; end
            else begin q = -q; p = q[DW-1:0]; end
        end
    endfunction

    task automatic expect_op(input logic [DW-1:0] b, input logic [DW-1:0] p, input logic ovf);
        exp_t e;
        e.p   = p;
        e.ovf = ovf;
        e.vc  = cyc + digits(b) + 2;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic r,
                         input logic [DW-1:0] p, input logic ovf);
        int t = 0;
        while (O_READY !== 1'b1 && t < 100) begin
            @(negedge I_CLK);
            t++;
        end
        if (O_READY !== 1'b1) begin
            total++; bad++;
            $display("FAIL issue_ready got=%b want=1", O_READY);
            return;
        end
        I_M1 = a; I_M2 = b; I_RND = r; I_VLD = 1'b1;
        expect_op(b, p, ovf);
        @(negedge I_CLK);
        I_VLD = 1'b0;
        I_M1  = 16'($urandom);
        I_M2  = 16'($urandom);
        I_RND = 1'($urandom);
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge I_CLK);
            t++;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s_timeout pending=%0d want=0", name, sb.size());
            sb.delete();
        end
        @(negedge I_CLK);
    endtask

    // Scoreboard: every result strobe must match the oldest outstanding expectation.
    always @(negedge I_CLK) begin
        if (I_RST_N === 1'b1) begin
            if (O_VLD === 1'b1) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_vld product=%h", O_PRODUCT);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (O_PRODUCT !== e.p || O_OVF !== e.ovf || cyc != e.vc) begin
                        bad++;
                        $display("FAIL result got=%h ovf=%b cyc=%0d want=%h ovf=%b cyc=%0d",
                                 O_PRODUCT, O_OVF, cyc, e.p, e.ovf, e.vc);
                    end
                end
            end else if (O_VLD !== 1'b0 || O_PRODUCT !== '0 || O_OVF !== 1'b0) begin
                total++; bad++;
                $display("FAIL idle_outputs vld=%b product=%h ovf=%b want 0/0000/0",
                         O_VLD, O_PRODUCT, O_OVF);
            end
        end
    end

    task automatic test_reset();
        I_RST_N = 1'b0; I_VLD = 1'b0; I_M1 = '0; I_M2 = '0; I_RND = 1'b0;
        repeat (3) @(negedge I_CLK);
        total++;
        if (O_READY !== 1'b1 || O_VLD !== 1'b0 || O_PRODUCT !== '0 || O_OVF !== 1'b0) begin
            bad++;
            $display("FAIL reset_state rdy=%b vld=%b product=%h ovf=%b want 1/0/0000/0",
                     O_READY, O_VLD, O_PRODUCT, O_OVF);
        end
        I_RST_N = 1'b1;
        @(negedge I_CLK);
    endtask

    task automatic test_basic();
        issue(16'h2000, 16'h2000, 1'b0, 16'h2000, 1'b0);
        drain("one_x_one");
        issue(16'hE000, 16'h1000, 1'b0, 16'hF000, 1'b0);
        drain("neg_half");
        issue(16'h7FFF, 16'h0000, 1'b0, 16'h0000, 1'b0);
        drain("zero_mult");
        issue(16'h7FFF, 16'h0001, 1'b0, 16'h0003, 1'b0);
        drain("one_digit");
    endtask

    task automatic test_saturation();
        issue(16'h7FFF, 16'h7FFF, 1'b0, 16'h7FFF, 1'b1);
        drain("sat_pos");
        issue(16'h8000, 16'h8000, 1'b0, 16'h7FFF, 1'b1);
        drain("sat_minmin");
        issue(16'h8000, 16'h2000, 1'b0, 16'h8000, 1'b0);
        drain("exact_min");
        issue(16'h8000, 16'h2001, 1'b0, 16'h8000, 1'b1);
        drain("sat_neg");
    endtask

    task automatic test_rounding();
        issue(16'h0001, 16'h1000, 1'b0, 16'h0000, 1'b0);
        issue(16'h0001, 16'h1000, 1'b1, 16'h0001, 1'b0);
        issue(16'hFFFF, 16'h1000, 1'b0, 16'h0000, 1'b0);
        issue(16'hFFFF, 16'h1000, 1'b1, 16'hFFFF, 1'b0);
        drain("rounding");
    endtask

    task automatic test_back_to_back();
        int t = 0;
        issue(16'h2000, 16'h2000, 1'b0, 16'h2000, 1'b0);
        while (O_VLD !== 1'b1 && t < 50) begin
            @(negedge I_CLK);
            t++;
        end
        total++;
        if (O_VLD !== 1'b1 || O_READY !== 1'b1) begin
            bad++;
            $display("FAIL b2b_ready vld=%b rdy=%b want 1/1", O_VLD, O_READY);
        end
        issue(16'hE000, 16'h1000, 1'b0, 16'hF000, 1'b0);
        drain("back_to_back");
    endtask

    task automatic test_handshake();
        logic [DW-1:0] a, b, p, mask;
        logic r, ovf;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0: mask = 16'hFFFF;
                1: mask = 16'h03FF;
                2: mask = 16'h001F;
                default: mask = 16'h0000;
            endcase
            a = 16'($urandom);
            b = 16'($urandom) & mask;
            r = 1'($urandom);
            I_M1 = a; I_M2 = b; I_RND = r; I_VLD = 1'b1;
            if (O_READY === 1'b1) begin
                model(a, b, r, p, ovf);
                expect_op(b, p, ovf);
            end
            @(negedge I_CLK);
        end
        I_VLD = 1'b0;
        drain("handshake");
    endtask

    task automatic test_reset_midop();
        issue(16'h7FFF, 16'h7FFF, 1'b0, 16'h7FFF, 1'b1);
        @(negedge I_CLK);
        I_RST_N = 1'b0;
        sb.delete();
        #1;
        total++;
        if (O_READY !== 1'b1 || O_VLD !== 1'b0 || O_PRODUCT !== '0 || O_OVF !== 1'b0) begin
            bad++;
            $display("FAIL midop_reset rdy=%b vld=%b product=%h ovf=%b want 1/0/0000/0",
                     O_READY, O_VLD, O_PRODUCT, O_OVF);
        end
        repeat (2) @(negedge I_CLK);
        I_RST_N = 1'b1;
        repeat (6) @(negedge I_CLK);
        total++;
        if (O_READY !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_ready got=%b want=1", O_READY);
        end
        issue(16'h2000, 16'h2000, 1'b0, 16'h2000, 1'b0);
        drain("post_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_rounding();
        test_back_to_back();
        test_handshake();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
